// File: rtl/carregador_de_instrucoes_if.sv
// Loader bus: host word handshake, instruction RAM port and load status.
// The loader is the master; the host/RAM side uses the slave view.
interface carregador_de_instrucoes_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              Inicio;
  logic              Dado_valido;
  logic [DATA_W-1:0] Dado;
  logic              Dado_pronto;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              Carga_concluida;
  logic              Erro;
  logic [DATA_W-1:0] Checksum;

  modport master (
    input  Inicio, Dado_valido, Dado, mem_q,
    output Dado_pronto, mem_address, mem_data, mem_wren,
           Carga_concluida, Erro, Checksum
  );

  modport slave (
    output Inicio, Dado_valido, Dado, mem_q,
    input  Dado_pronto, mem_address, mem_data, mem_wren,
           Carga_concluida, Erro, Checksum
  );
endinterface

// File: rtl/carregador_de_instrucoes.sv
// Instruction RAM loader: writes host words to addresses 0..N-1, reads them
// back and compares additive checksums before releasing the fetch unit.
//
// state     | meaning
// OCIOSO    | idle after reset, waiting for Inicio
// ESCRITA   | accepting host words and writing them to RAM
// VERIFICA  | presenting addresses 0..N-1 for read-back
// DRENO     | last read word arriving, final checksum compare
// CONCLUIDO | load verified, Carga_concluida held high
// ERRO      | checksum mismatch, Erro held high
module carregador_de_instrucoes #(
  parameter int NUM_PALAVRAS = 16,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  carregador_de_instrucoes_if.master    bus
);

  typedef enum logic [2:0] {
    OCIOSO,
    ESCRITA,
    VERIFICA,
    DRENO,
    CONCLUIDO,
    ERRO
  } estado_t;

  localparam logic [ADDR_W:0] ULTIMO = (ADDR_W+1)'(NUM_PALAVRAS - 1);
  localparam logic [ADDR_W:0] UM     = (ADDR_W+1)'(1);

  estado_t           estado_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] soma_escrita_q;
  logic [DATA_W-1:0] soma_lida_q;
  logic [DATA_W-1:0] soma_lida_d;
  logic              leitura_valida_q;
  logic              dado_pronto_q;
  logic              concluida_q;
  logic              erro_q;

  // Read data lags the address by one cycle, so the last word is folded in
  // combinationally during DRENO.
  assign soma_lida_d = soma_lida_q + bus.mem_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q         <= OCIOSO;
      cnt_q            <= '0;
      soma_escrita_q   <= '0;
      soma_lida_q      <= '0;
      leitura_valida_q <= 1'b0;
      dado_pronto_q    <= 1'b0;
      concluida_q      <= 1'b0;
      erro_q           <= 1'b0;
    end else begin
      leitura_valida_q <= (estado_q == VERIFICA);
      if (leitura_valida_q) begin
        soma_lida_q <= soma_lida_d;
      end

      case (estado_q)
        OCIOSO, CONCLUIDO, ERRO: begin
          if (bus.Inicio) begin
            estado_q       <= ESCRITA;
            cnt_q          <= '0;
            soma_escrita_q <= '0;
            soma_lida_q    <= '0;
            dado_pronto_q  <= 1'b1;
            concluida_q    <= 1'b0;
            erro_q         <= 1'b0;
          end
        end

        ESCRITA: begin
          if (bus.Dado_valido) begin
            soma_escrita_q <= soma_escrita_q + bus.Dado;
            if (cnt_q == ULTIMO) begin
              estado_q      <= VERIFICA;
              cnt_q         <= '0;
              dado_pronto_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + UM;
            end
          end
        end

        VERIFICA: begin
          cnt_q <= cnt_q + UM;
          if (cnt_q == ULTIMO) begin
            estado_q <= DRENO;
          end
        end

        DRENO: begin
          if (soma_lida_d == soma_escrita_q) begin
            estado_q    <= CONCLUIDO;
            concluida_q <= 1'b1;
          end else begin
            estado_q <= ERRO;
            erro_q   <= 1'b1;
          end
        end

        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  // The RAM samples on the same edge, so reset must kill the write immediately.
  assign bus.mem_wren    = (estado_q == ESCRITA) && bus.Dado_valido && !Reset;
  assign bus.mem_address = ((estado_q == ESCRITA) || (estado_q == VERIFICA))
                           ? cnt_q[ADDR_W-1:0] : '0;
  assign bus.mem_data    = (estado_q == ESCRITA) ? bus.Dado : '0;

  assign bus.Dado_pronto     = dado_pronto_q;
  assign bus.Carga_concluida = concluida_q;
  assign bus.Erro            = erro_q;
  assign bus.Checksum        = soma_escrita_q;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Bench for the instruction loader: RAM model with optional read corruption,
// directed and randomized loads checked against a checksum/write-order model.
module tb_carregador_de_instrucoes;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  int   ciclo = 0;
  int   checks = 0;
  int   errors = 0;

  carregador_de_instrucoes_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  carregador_de_instrucoes #(
    .NUM_PALAVRAS(N),
    .ADDR_W(4),
    .DATA_W(16)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  logic [15:0] ram [N];
  logic [15:0] palavras [N];
  bit          corrompe = 1'b0;
  int          log_addr[$];
  int          log_data[$];

  // RAM: synchronous write, registered read; address 7 may read back as 0.
  always @(posedge clk) begin
    if (bus.mem_wren) begin
      ram[bus.mem_address] <= bus.mem_data;
      log_addr.push_back(int'(bus.mem_address));
      log_data.push_back(int'(bus.mem_data));
    end
    bus.mem_q <= (corrompe && bus.mem_address == 4'd7) ? 16'h0000 : ram[bus.mem_address];
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    assert (obs === esp) else begin
      errors++;
      $error("FAIL %s: observado=0x%0h esperado=0x%0h", tag, obs, esp);
    end
  endtask

  task automatic saidas_zeradas(input string tag);
    verifica({tag, "_pronto"},    bus.Dado_pronto, 0);
    verifica({tag, "_wren"},      bus.mem_wren, 0);
    verifica({tag, "_addr"},      bus.mem_address, 0);
    verifica({tag, "_data"},      bus.mem_data, 0);
    verifica({tag, "_concluida"}, bus.Carga_concluida, 0);
    verifica({tag, "_erro"},      bus.Erro, 0);
    verifica({tag, "_checksum"},  bus.Checksum, 0);
  endtask

  // modo 0: back-to-back, 1: valid every other cycle, 2: random gaps.
  // reset_em >= 0 asserts Reset in the cycle that writes that address.
  task automatic carregar(input int modo, input bit inicio_extra, input int reset_em);
    int i = 0;
    int k = 0;
    int n = 0;
    int t_aceite;
    bit v;
    logic [15:0] soma_esp = 16'h0;
    logic [15:0] soma_lida_esp = 16'h0;
    bit ok_esp;

    for (int j = 0; j < N; j++) begin
      soma_esp      += palavras[j];
      soma_lida_esp += (corrompe && j == 7) ? 16'h0 : palavras[j];
    end
    ok_esp = (soma_esp == soma_lida_esp);

    log_addr.delete();
    log_data.delete();
    bus.Inicio = 1'b1;
    @(negedge clk);
    bus.Inicio = 1'b0;
    verifica("inicio_pronto", bus.Dado_pronto, 1);
    verifica("inicio_concluida", bus.Carga_concluida, 0);
    verifica("inicio_erro", bus.Erro, 0);

    while (i < N) begin
      case (modo)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.Dado_valido = v;
      bus.Dado        = v ? palavras[i] : 16'($urandom);
      bus.Inicio      = (inicio_extra && k == 3);
      if (v && i == reset_em) begin
        rst = 1'b1;
        #1;
        verifica("reset_bloqueia_wren", bus.mem_wren, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.Dado_valido = 1'b0;
        #1;
        saidas_zeradas("pos_reset");
        verifica("pos_reset_escritas", log_addr.size(), reset_em);
        return;
      end
      #1;
      verifica("escrita_pronto", bus.Dado_pronto, 1);
      verifica("escrita_wren", bus.mem_wren, v);
      if (v) begin
        verifica("escrita_addr", bus.mem_address, i);
        verifica("escrita_data", bus.mem_data, palavras[i]);
      end
      @(negedge clk);
      if (v) i++;
      k++;
    end
    bus.Dado_valido = 1'b0;
    bus.Inicio      = 1'b0;
    t_aceite = ciclo;

    while (!(bus.Carga_concluida || bus.Erro) && n < 100) begin
      bus.Inicio = (inicio_extra && n == 4);
      @(negedge clk);
      n++;
    end
    bus.Inicio = 1'b0;
    verifica("fim_sem_timeout", (n < 100), 1);
    verifica("latencia_fim", ciclo - t_aceite, 17);
    verifica("carga_concluida", bus.Carga_concluida, ok_esp);
    verifica("erro", bus.Erro, !ok_esp);
    verifica("checksum", bus.Checksum, soma_esp);
    verifica("n_escritas", log_addr.size(), N);
    if (log_addr.size() == N) begin
      for (int j = 0; j < N; j++) begin
        verifica("log_addr", log_addr[j], j);
        verifica("log_data", log_data[j], palavras[j]);
      end
    end

    // Host words after completion must not reach the RAM.
    bus.Dado_valido = 1'b1;
    repeat (3) @(negedge clk);
    bus.Dado_valido = 1'b0;
    verifica("sem_escrita_pos_fim", log_addr.size(), N);
    verifica("status_mantido", bus.Carga_concluida, ok_esp);
  endtask

  initial begin
    rst             = 1'b1;
    bus.Inicio      = 1'b0;
    bus.Dado_valido = 1'b0;
    bus.Dado        = '0;
    repeat (3) @(negedge clk);
    saidas_zeradas("durante_reset");
    rst = 1'b0;
    @(negedge clk);
    saidas_zeradas("ocioso");

    for (int j = 0; j < N; j++) palavras[j] = 16'(j + 1);
    carregar(0, 1'b0, -1);
    verifica("checksum_0x88", bus.Checksum, 16'h0088);

    carregar(1, 1'b0, -1);
    verifica("checksum_0x88_gaps", bus.Checksum, 16'h0088);

    for (int j = 0; j < N; j++) palavras[j] = 16'hFFFF;
    carregar(0, 1'b0, -1);
    verifica("checksum_wrap", bus.Checksum, 16'hFFF0);

    for (int j = 0; j < N; j++) palavras[j] = 16'(j + 1);
    corrompe = 1'b1;
    carregar(0, 1'b0, -1);
    verifica("corrompido_erro", bus.Erro, 1);
    verifica("corrompido_checksum", bus.Checksum, 16'h0088);
    corrompe = 1'b0;

    carregar(0, 1'b0, 5);
    carregar(0, 1'b0, -1);

    carregar(0, 1'b1, -1);

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < N; j++) palavras[j] = 16'($urandom);
      if (r == 2) palavras[7] = 16'h0000;
      corrompe = 1'($urandom_range(0, 1));
      if (r == 2) corrompe = 1'b1;
      carregar(2, 1'($urandom_range(0, 1)), -1);
    end
    corrompe = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/carregador_de_instrucoes.md
Name: carregador_de_instrucoes

Overview:
Writes a program into the instruction RAM (memoram) before the instruction fetch queue reads it; it is the writer on the same address/data/wren/q port.
- Accepts instruction words from a host over a valid/ready handshake and writes them to consecutive addresses starting at 0.
- Reads every word back and checks a 16-bit additive checksum.
- Flags done or error; the fetch unit is held in reset until `Carga_concluida`.

Parameters:
- NUM_PALAVRAS, 16, number of words loaded per run (1..2^ADDR_W).
- ADDR_W, 4, memory address width.
- DATA_W, 16, instruction/data width.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Inicio  in  1  start pulse; sampled only in OCIOSO, CONCLUIDO, ERRO.
- Dado_valido  in  1  host word valid.
- Dado  in  DATA_W  host instruction word.
- Dado_pronto  out  1  loader ready to accept a word.
- mem_address  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data; valid the cycle after the address is sampled.
- Carga_concluida  out  1  level: load verified OK.
- Erro  out  1  level: checksum mismatch.
- Checksum  out  DATA_W  sum of written words, mod 2^DATA_W.

Behaviour:
- States: OCIOSO, ESCRITA, VERIFICA, DRENO, CONCLUIDO, ERRO.
- Registers: cnt (ADDR_W+1 bits), soma_escrita, soma_lida, leitura_valida.
- Reset: state=OCIOSO; cnt, sums and leitura_valida = 0.
- All outputs are 0 during and after reset until Inicio: mem_wren, Dado_pronto, Carga_concluida, Erro, mem_address, mem_data, Checksum.
- mem_wren is combinationally gated by !Reset, so a reset asserted mid-write blocks the write in that same cycle.
- OCIOSO/CONCLUIDO/ERRO, on Inicio=1: go to ESCRITA; clear cnt and both sums; Carga_concluida and Erro drop at that edge.
- ESCRITA outputs: Dado_pronto=1; mem_address=cnt[ADDR_W-1:0]; mem_data=Dado; mem_wren=Dado_valido (combinational; RAM samples on the same edge).
- ESCRITA, on each edge with Dado_valido=1:
  - soma_escrita += Dado (wraps mod 2^DATA_W);
  - cnt += 1;
  - if cnt == NUM_PALAVRAS-1: go to VERIFICA, cnt=0.
- ESCRITA: Dado_valido=0 cycles insert gaps with no write and no count. Inicio is ignored.
- VERIFICA outputs: mem_address=cnt; mem_wren=0; Dado_pronto=0. cnt += 1 every cycle.
- VERIFICA: after the cycle with cnt == NUM_PALAVRAS-1, go to DRENO.
- leitura_valida: registered copy of (state==VERIFICA).
- Read-back accumulate: on each edge with leitura_valida=1, soma_lida += mem_q. Address k presented in cycle k is accumulated at the end of cycle k+1.
- DRENO (1 cycle): at its edge, go to CONCLUIDO if (soma_lida + mem_q) == soma_escrita, else ERRO.
- Latency: Carga_concluida/Erro assert NUM_PALAVRAS+1 edges after the VERIFICA entry edge.
- CONCLUIDO: Carga_concluida=1. ERRO: Erro=1. Both hold until Inicio or Reset.
- Checksum = soma_escrita at all times.
- Inicio and Dado_valido are ignored in VERIFICA and DRENO.
- Dado_valido is ignored in OCIOSO, CONCLUIDO and ERRO; no write occurs.
- Reset mid-operation: back to OCIOSO next edge. Partially written RAM contents are left as is.
- Carga_concluida and Erro are never 1 simultaneously.

Test Plan:
- Reset, Inicio, 16 back-to-back words 0x0001..0x0010, bench RAM model:
  - 16 writes to addresses 0..15;
  - Checksum=0x0088;
  - Carga_concluida=1 exactly 17 edges after the last accept;
  - Erro=0.
- Same load with Dado_valido toggled 1/0 every cycle: exactly 16 writes, addresses contiguous, no write in gap cycles, same 0x0088 result.
- 16 words of 0xFFFF: Checksum wraps to 0xFFF0; Carga_concluida=1.
- RAM model returns 0x0000 for address 7 on read-back (write of 0x0008 dropped): Erro=1, Carga_concluida=0, Checksum=0x0088.
- Reset asserted in the cycle writing address 5 with Dado_valido=1:
  - mem_wren=0 in that cycle;
  - state OCIOSO, all outputs 0 next cycle;
  - a new Inicio plus 16 words completes with Carga_concluida=1.
- Inicio pulsed during ESCRITA and during VERIFICA: no restart, same done timing. Inicio in CONCLUIDO: Carga_concluida drops, Dado_pronto=1 next cycle.
